// File: rtl/fp_add_share_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp_add_share_arbiter: round-robin sharing of one pipelined FP32 adder among |
// | NUM_REQ requesters, with a tag shadow pipe routing results back to owners.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fp_add_share_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADD_LAT    = 3,
   parameter int MAX_OUT    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   output logic                          add_vld_in,
   output logic                          add_en,
   input  logic [DATA_WIDTH-1:0]         add_result,
   input  logic                          add_vld_out,
   output logic                          err_sticky
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [TAG_W-1:0] rr_q, rr_d;
   logic [ADD_LAT-1:0] vld_q, vld_d;
   logic [TAG_W-1:0] tag_q [ADD_LAT];
   logic [TAG_W-1:0] tag_d [ADD_LAT];
   logic [CNT_W-1:0] outst_q [NUM_REQ];
   logic [CNT_W-1:0] outst_d [NUM_REQ];
   logic err_q, err_d;

   logic             head_vld;
   logic [TAG_W-1:0] head_tag;
   logic             head_ready;
   logic             issue;
   logic [TAG_W-1:0] grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] fire;
   int               sel;

   // The adder only freezes when its oldest result has nowhere to go.
   always_comb begin
      head_vld   = vld_q[ADD_LAT-1];
      head_tag   = tag_q[ADD_LAT-1];
      head_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head_tag == TAG_W'(i)) begin
            head_ready = rsp_ready[i];
         end
      end
      add_en = !(head_vld && !head_ready);
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign eligible[gi]  = req_valid[gi] && (outst_q[gi] < CNT_W'(MAX_OUT));
         assign rsp_valid[gi] = head_vld && (head_tag == TAG_W'(gi));
         assign fire[gi]      = rsp_valid[gi] && rsp_ready[gi];
      end
   endgenerate

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      issue     = 1'b0;
      sel       = 0;
      add_a     = '0;
      add_b     = '0;
      if (add_en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sel = (int'(rr_q) + k) % NUM_REQ;
            if (!issue && eligible[sel]) begin
               issue      = 1'b1;
               grant[sel] = 1'b1;
               grant_idx  = TAG_W'(sel);
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            add_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            add_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign req_ready  = grant;
   assign add_vld_in = issue;
   assign rsp_data   = add_result;
   assign err_sticky = err_q;

   // Shadow pipe moves in lockstep with the adder so the head tag names the result owner.
   always_comb begin
      rr_d  = issue ? TAG_W'((int'(grant_idx) + 1) % NUM_REQ) : rr_q;
      vld_d = vld_q;
      for (int s = 0; s < ADD_LAT; s++) begin
         tag_d[s] = tag_q[s];
      end
      if (add_en) begin
         vld_d[0] = issue;
         tag_d[0] = grant_idx;
         for (int s = 1; s < ADD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            tag_d[s] = tag_q[s-1];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         outst_d[i] = outst_q[i] + CNT_W'(grant[i]) - CNT_W'(fire[i]);
      end
      err_d = err_q | (add_vld_out != head_vld);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q  <= '0;
         vld_q <= '0;
         err_q <= 1'b0;
         for (int s = 0; s < ADD_LAT; s++) begin
            tag_q[s] <= '0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            outst_q[i] <= '0;
         end
      end else begin
         rr_q  <= rr_d;
         vld_q <= vld_d;
         err_q <= err_d;
         for (int s = 0; s < ADD_LAT; s++) begin
            tag_q[s] <= tag_d[s];
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            outst_q[i] <= outst_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_share_arbiter.sv
`default_nettype none
// Table-driven bench for fp_add_share_arbiter with a behavioural FP32 adder model,
// plus a second instance with MAX_OUT=2 to exercise the outstanding limit.
module tb_fp_add_share_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   rsp_data, add_a, add_b, add_result;
   logic           add_vld_in, add_en, add_vld_out, err_sticky;
   logic           force_vld;

   logic [N-1:0]   req_valid2, req_ready2, rsp_valid2, rsp_ready2;
   logic [W-1:0]   rsp_data2, add_a2, add_b2;
   logic           add_vld_in2, add_en2, err_sticky2;

   fp_add_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ADD_LAT(L), .MAX_OUT(4)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .add_a(add_a), .add_b(add_b), .add_vld_in(add_vld_in),
      .add_en(add_en), .add_result(add_result), .add_vld_out(add_vld_out),
      .err_sticky(err_sticky)
   );

   logic [L-1:0] m2_vld;
   fp_add_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ADD_LAT(L), .MAX_OUT(2)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
      .rsp_data(rsp_data2), .add_a(add_a2), .add_b(add_b2), .add_vld_in(add_vld_in2),
      .add_en(add_en2), .add_result(32'h0), .add_vld_out(m2_vld[L-1]),
      .err_sticky(err_sticky2)
   );

   // FP32 <-> real for normal numbers and zero; enough for the exact sums used here.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      int e;
      if (f[30:0] == 31'd0) return 0.0;
      e = int'(f[30:23]) - 127 + 1023;
      b = {f[31], e[10:0], f[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      int e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   logic [L-1:0] m_vld;
   logic [W-1:0] m_res [L];
   always @(posedge clk) begin
      if (rst) begin
         m_vld  <= '0;
         m2_vld <= '0;
      end else begin
         if (add_en) begin
            m_vld[0] <= add_vld_in;
            m_res[0] <= r2f(f2r(add_a) + f2r(add_b));
            for (int s = 1; s < L; s++) begin
               m_vld[s] <= m_vld[s-1];
               m_res[s] <= m_res[s-1];
            end
         end
         if (add_en2) begin
            m2_vld <= {m2_vld[L-2:0], add_vld_in2};
         end
      end
   end
   assign add_vld_out = m_vld[L-1] | force_vld;
   assign add_result  = m_res[L-1];

   typedef struct {
      bit          rst;
      bit          frc;
      bit          chk;
      logic [3:0]  rv;
      logic [3:0]  rr;
      logic [3:0]  rdy;
      logic [3:0]  rsp;
      bit          en;
      bit          err;
      logic [31:0] data;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] opa [N];
   logic [31:0] opb [N];
   logic [31:0] res [N];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          cur_row;

   task automatic add_row(input bit r, input bit f, input bit c, input logic [3:0] rv,
                          input logic [3:0] rr, input logic [3:0] rdy, input logic [3:0] rsp,
                          input bit en, input bit err, input logic [31:0] data);
      vec_t v;
      v.rst = r; v.frc = f; v.chk = c; v.rv = rv; v.rr = rr; v.rdy = rdy;
      v.rsp = rsp; v.en = en; v.err = err; v.data = data;
      vq.push_back(v);
   endtask

   task automatic reset_row();
      add_row(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
      end
   endtask

   initial begin
      opa[0] = 32'h3F800000; opb[0] = 32'h40000000; res[0] = 32'h40400000; // 1+2
      opa[1] = 32'h40000000; opb[1] = 32'h40000000; res[1] = 32'h40800000; // 2+2
      opa[2] = 32'h3F800000; opb[2] = 32'h3F800000; res[2] = 32'h40000000; // 1+1
      opa[3] = 32'h40400000; opb[3] = 32'h40800000; res[3] = 32'h40E00000; // 3+4
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = opa[i];
         req_b[i*W +: W] = opb[i];
      end
      req_valid = '0; rsp_ready = '1; force_vld = 1'b0;
      req_valid2 = '0; rsp_ready2 = '1;

      // single req0 operation
      reset_row();
      add_row(0, 0, 1, 4'h1, 4'hF, 4'h1, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h1, 1, 0, res[0]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      // all requesters busy: rotating grants, responses in tag order
      reset_row();
      for (int c = 0; c < 10; c++) begin
         add_row(0, 0, 1, 4'hF, 4'hF, 4'(1 << (c % 4)),
                 (c >= 3) ? 4'(1 << ((c - 3) % 4)) : 4'h0, 1, 0,
                 (c >= 3) ? res[(c - 3) % 4] : 32'h0);
      end
      // reset with three ops in flight
      reset_row();
      add_row(0, 0, 1, 4'hF, 4'hF, 4'h1, 4'h0, 1, 0, 32'h0);
      // head stall on requester 1
      reset_row();
      add_row(0, 0, 1, 4'h2, 4'hF, 4'h2, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      for (int c = 0; c < 5; c++) begin
         add_row(0, 0, 1, 4'h5, 4'hD, 4'h0, 4'h2, 0, 0, res[1]);
      end
      add_row(0, 0, 1, 4'h5, 4'hF, 4'h4, 4'h2, 1, 0, res[1]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h4, 1, 0, res[2]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      // req2 continuous with its response blocked
      reset_row();
      for (int c = 0; c < 3; c++) add_row(0, 0, 1, 4'h4, 4'hB, 4'h4, 4'h0, 1, 0, 32'h0);
      add_row(0, 0, 1, 4'h4, 4'hB, 4'h0, 4'h4, 0, 0, res[2]);
      add_row(0, 0, 1, 4'h4, 4'hB, 4'h0, 4'h4, 0, 0, res[2]);
      add_row(0, 0, 1, 4'h4, 4'hF, 4'h4, 4'h4, 1, 0, res[2]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h4, 1, 0, res[2]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h4, 1, 0, res[2]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h4, 1, 0, res[2]);
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      // spurious adder valid -> sticky error until reset
      reset_row();
      add_row(0, 1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);
      for (int c = 0; c < 3; c++) add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 1, 32'h0);
      reset_row();
      add_row(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 32'h0);

      for (int r = 0; r < vq.size(); r++) begin
         @(negedge clk);
         cur_row   = r;
         rst       = vq[r].rst;
         force_vld = vq[r].frc;
         req_valid = vq[r].rv;
         rsp_ready = vq[r].rr;
         #2;
         if (vq[r].chk) begin
            check("req_ready", 32'(req_ready), 32'(vq[r].rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(vq[r].rsp));
            check("add_en", 32'(add_en), 32'(vq[r].en));
            check("add_vld_in", 32'(add_vld_in), 32'(|vq[r].rdy));
            check("err_sticky", 32'(err_sticky), 32'(vq[r].err));
            if (vq[r].rsp != 4'h0) check("rsp_data", rsp_data, vq[r].data);
            for (int i = 0; i < N; i++) begin
               if (vq[r].rdy[i]) begin
                  check("add_a", add_a, opa[i]);
                  check("add_b", add_b, opb[i]);
               end
            end
         end
      end

      // MAX_OUT=2 instance: two issues, then blocked until a result retires
      cur_row = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         force_vld  = 1'b0;
         req_valid  = '0;
         req_valid2 = 4'h1;
         #2;
         check("max_out_grant", 32'(req_ready2), ((c % 4) < 2) ? 32'h1 : 32'h0);
      end
      check("max_out_err", 32'(err_sticky2), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
